ping_pong_monitor: RTL and testbench
====================================

Name: ping_pong_monitor

Overview:
- Receive-side checker for the 4-bit ping-pong counter stream (count value plus direction flag).
- Samples the stream when `valid` is high and locks onto the sequence after LOCK_LEN consecutive legal steps.
- Flags any illegal step and counts bounces and errors.
- Sits downstream of the counter in lab top levels and drives LEDs/7-seg status.

Parameters:
- WIDTH, 4: width of count_in.
- LOCK_LEN, 3: consecutive legal samples (including the first) required to lock; legal range 2..15.
- CNT_W, 8: width of the bounce and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  count_in/dir_in carry a new sample this cycle (tied to the producer's enable).
- count_in  in  WIDTH  sampled counter value.
- dir_in  in  1  sampled direction (1 = last step up, 0 = last step down).
- clear  in  1  synchronous; leave FAULT, zero err_cnt, return to HUNT.
- locked  out  1  high while in LOCKED.
- fault  out  1  high while in FAULT (sticky).
- err_pulse  out  1  one-cycle pulse on a detected illegal step.
- bounce_cnt  out  CNT_W  saturating count of direction reversals while LOCKED.
- err_cnt  out  CNT_W  saturating count of illegal steps.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state = HUNT; locked, fault, err_pulse = 0; bounce_cnt, err_cnt = 0; ref regs (ref_v, ref_d) = 0; match_cnt = 0.
- Latency: all outputs registered. Effect of the sample at edge N is visible after edge N.
- Expected successor of a reference (v,d):
  - nd = 0 if v == all-ones; else nd = 1 if v == 0; else nd = d.
  - exp_v = nd ? v+1 : v-1 (WIDTH bits); exp_d = nd.
  - A sample matches iff count_in == exp_v and dir_in == exp_d.
- Any accepted valid sample becomes the new (ref_v, ref_d). Accepted means every valid sample except in FAULT or when clear is high.
- valid = 0: no state, counter, or ref change. Duplicate values are never seen because valid gates them.
- HUNT: on valid → capture ref, match_cnt = 1, go TRACK.
- TRACK, on valid:
  - Match → match_cnt+1; if that reaches LOCK_LEN → LOCKED.
  - Mismatch → match_cnt = 1, stay TRACK (resync on this sample; no err_pulse, no err_cnt change).
- LOCKED, on valid:
  - Match → stay. If dir_in != ref_d, bounce_cnt+1, saturating at all-ones.
  - Mismatch → err_pulse = 1 for one cycle, err_cnt+1 saturating, go FAULT. bounce_cnt is not incremented.
- FAULT: samples ignored and ref regs frozen; fault held until clear.
- clear (any state): go HUNT, err_cnt = 0, match_cnt = 0, err_pulse = 0. bounce_cnt is untouched (reset only by rst_n).
  - clear has priority over a simultaneous valid; that sample is discarded.
- rst_n low mid-operation: immediate return to reset values regardless of clk.
- Boundaries:
  - Reversal at all-ones: ref (15,1) → legal (14,0).
  - Reversal at zero: ref (0,0) → legal (1,1).
  - (15,1) → (0,1) wrap is illegal.
  - (0,x) → (15,0) is illegal.
- Output decode: locked = (state == LOCKED); fault = (state == FAULT).

Decomposition:
- Shared package ping_pong_pkg:
  - state enum {HUNT, TRACK, LOCKED, FAULT}.
  - WIDTH default, CNT_W default.
  - Function pp_next(v,d) returning {exp_d, exp_v}. The counter and monitor testbench reuse it.
- One natural sub-module: sat_counter (parameterized CNT_W, inc, clr), instantiated twice for bounce_cnt and err_cnt.
- FSM and compare logic stay in the top.

Test Plan:
- Reset then drive the counter stream 0,1,2 (dir=1) with valid each cycle → locked rises after the 3rd sample edge; err_pulse never asserts.
- Locked stream 13,14,15 (d=1) then 14 (d=0), 13 (d=0) → bounce_cnt increments once, at the 14/d=0 sample; locked stays 1.
- Locked at (15,1), inject (0,1) → err_pulse high for exactly one cycle, err_cnt = 1, fault = 1, locked = 0. Further samples leave all outputs unchanged.
- In FAULT, assert clear together with valid carrying (5,1) → next cycle state HUNT, err_cnt = 0, fault = 0, bounce_cnt unchanged; (5,1) is not captured.
- TRACK with samples (3,1),(4,1),(9,1),(10,1),(11,1) → no err_pulse; resync at 9; locked after the 11 sample.
- Assert rst_n low asynchronously mid-stream between edges → all outputs 0 immediately. 300 bounces then force saturation → bounce_cnt holds at 255.

Source files
------------

// File: rtl/ping_pong_pkg.sv
// ----------------------------------------------------------------------------
// ping_pong_pkg
//   Shared definitions for the 4-bit ping-pong counter and its receive-side
//   monitor.
//   - pp_state_e : monitor FSM encoding (HUNT, TRACK, LOCKED, FAULT).
//   - PP_WIDTH / PP_CNT_W : default count width and status-counter width.
//   - pp_next()  : expected successor {exp_d, exp_v} of a reference (v, d)
//                  for any count width up to PP_MAX_W bits.
// ----------------------------------------------------------------------------
package ping_pong_pkg;

  localparam int unsigned PP_WIDTH = 4;
  localparam int unsigned PP_CNT_W = 8;
  localparam int unsigned PP_MAX_W = 16;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2,
    FAULT  = 2'd3
  } pp_state_e;

  // Successor of (v, d) for a counter that is w bits wide. The value is
  // zero-extended into PP_MAX_W bits; the result's upper bits stay zero so a
  // caller can compare the whole vector against a zero-extended sample.
  // Direction flips at the two end stops; otherwise it is kept.
  function automatic logic [PP_MAX_W:0] pp_next(input logic [PP_MAX_W-1:0] v,
                                                input logic                d,
                                                input int unsigned         w);
    logic [PP_MAX_W-1:0] mask;
    logic [PP_MAX_W-1:0] v_m;
    logic [PP_MAX_W-1:0] exp_v;
    logic                nd;
    mask = '0;
    for (int i = 0; i < PP_MAX_W; i++) begin
      if (i < w) mask[i] = 1'b1;
    end
    v_m = v & mask;
    if (v_m == mask)    nd = 1'b0;
    else if (v_m == '0) nd = 1'b1;
    else                nd = d;
    exp_v = (nd ? v_m + PP_MAX_W'(1) : v_m - PP_MAX_W'(1)) & mask;
    return {nd, exp_v};
  endfunction

endpackage

// File: rtl/ping_pong_monitor_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear (clear wins over inc).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : add one this cycle unless already at all-ones
//     clr        : synchronous return to zero
//     count      : current value (CNT_W bits)
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ping_pong_monitor.sv
// ----------------------------------------------------------------------------
// ping_pong_monitor
//   Receive-side checker for the ping-pong counter stream. Each valid sample
//   is compared with the successor of the previous accepted sample; after
//   LOCK_LEN consecutive legal samples the monitor locks, and any illegal
//   step while locked raises a one-cycle err_pulse and parks in a sticky
//   FAULT state until clear.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     valid      : count_in/dir_in carry a new sample
//     count_in   : sampled counter value (WIDTH bits)
//     dir_in     : sampled direction (1 = last step up)
//     clear      : synchronous; back to HUNT, zero err_cnt (wins over valid)
//     locked     : high while LOCKED
//     fault      : high while FAULT
//     err_pulse  : one-cycle pulse on an illegal step while LOCKED
//     bounce_cnt : saturating count of legal reversals while LOCKED
//     err_cnt    : saturating count of illegal steps
//   LOCK_LEN must lie in 2..15 (match_cnt is 4 bits).
// ----------------------------------------------------------------------------
module ping_pong_monitor
  import ping_pong_pkg::*;
#(
  parameter int unsigned WIDTH    = PP_WIDTH,
  parameter int unsigned LOCK_LEN = 3,
  parameter int unsigned CNT_W    = PP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] count_in,
  input  logic             dir_in,
  input  logic             clear,
  output logic             locked,
  output logic             fault,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bounce_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_HUNT   = 2'(HUNT);
  localparam logic [1:0] ST_TRACK  = 2'(TRACK);
  localparam logic [1:0] ST_LOCKED = 2'(LOCKED);
  localparam logic [1:0] ST_FAULT  = 2'(FAULT);

  localparam int unsigned         MATCH_W   = 4;
  // match_cnt value that, plus the current matching sample, reaches LOCK_LEN.
  localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_LEN - 1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   ref_v;
  logic               ref_d;
  logic [MATCH_W-1:0] match_cnt;

  logic [PP_MAX_W:0]  nxt;
  logic               match;
  logic               locked_valid;
  logic               bounce_inc;
  logic               err_inc;

  // Expected successor of the reference; upper bits of nxt are zero, so the
  // whole vector is compared against the zero-extended sample.
  assign nxt   = pp_next(PP_MAX_W'(ref_v), ref_d, WIDTH);
  assign match = (nxt[PP_MAX_W-1:0] == PP_MAX_W'(count_in)) &&
                 (nxt[PP_MAX_W] == dir_in);

  assign locked_valid = valid && !clear && (state == ST_LOCKED);
  // A legal step whose direction differs from the reference is a reversal.
  assign bounce_inc   = locked_valid && match && (dir_in != ref_d);
  assign err_inc      = locked_valid && !match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      ref_v     <= '0;
      ref_d     <= 1'b0;
      match_cnt <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (clear) begin
        // The simultaneous sample, if any, is discarded.
        state     <= ST_HUNT;
        match_cnt <= '0;
      end else if (valid) begin
        case (state)
          ST_HUNT: begin
            ref_v     <= count_in;
            ref_d     <= dir_in;
            match_cnt <= MATCH_W'(1);
            state     <= ST_TRACK;
          end
          ST_TRACK: begin
            ref_v <= count_in;
            ref_d <= dir_in;
            if (match) begin
              match_cnt <= match_cnt + MATCH_W'(1);
              if (match_cnt == LOCK_LAST) state <= ST_LOCKED;
            end else begin
              // Resynchronise on this sample without flagging an error.
              match_cnt <= MATCH_W'(1);
            end
          end
          ST_LOCKED: begin
            ref_v <= count_in;
            ref_d <= dir_in;
            if (!match) begin
              err_pulse <= 1'b1;
              state     <= ST_FAULT;
            end
          end
          default: begin
            // FAULT: samples ignored, reference frozen until clear.
          end
        endcase
      end
    end
  end

  assign locked = (state == ST_LOCKED);
  assign fault  = (state == ST_FAULT);

  // bounce_cnt is cleared only by rst_n.
  sat_counter #(.CNT_W(CNT_W)) u_bounce_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bounce_inc),
    .clr   (1'b0),
    .count (bounce_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (clear),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_ping_pong_monitor.sv
// ----------------------------------------------------------------------------
// tb_ping_pong_monitor
//   Directed bench for ping_pong_monitor. Inputs change 1 ns after a rising
//   edge; outputs are sampled 1 ns after the edge that consumed the sample.
// ----------------------------------------------------------------------------
module tb_ping_pong_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid;
  logic [3:0] count_in;
  logic       dir_in;
  logic       clear;
  logic       locked;
  logic       fault;
  logic       err_pulse;
  logic [7:0] bounce_cnt;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;

  ping_pong_monitor dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .count_in   (count_in),
    .dir_in     (dir_in),
    .clear      (clear),
    .locked     (locked),
    .fault      (fault),
    .err_pulse  (err_pulse),
    .bounce_cnt (bounce_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // One valid sample consumed by the next rising edge.
  task automatic drive(input logic [3:0] v, input logic d);
    count_in = v;
    dir_in   = d;
    valid    = 1'b1;
    @(posedge clk);
    #1;
    valid    = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; count_in = '0; dir_in = 1'b0; clear = 1'b0;
    #2;
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", fault); end
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
    tests++; if (bounce_cnt !== 8'd0) begin fails++; $display("FAIL reset_bounce: got %0d want 0", bounce_cnt); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    idle();
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_lock();
    drive(4'd0, 1'b1);
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_s1: got %b want 0", locked); end
    drive(4'd1, 1'b1);
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_s2: got %b want 0", locked); end
    drive(4'd2, 1'b1);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_s3: got %b want 1", locked); end
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL lock_no_err: got %b want 0", err_pulse); end
  endtask

  task automatic test_bounce();
    for (int v = 3; v <= 15; v++) drive(4'(v), 1'b1);
    tests++; if (bounce_cnt !== 8'd0) begin fails++; $display("FAIL bounce_before: got %0d want 0", bounce_cnt); end
    drive(4'd14, 1'b0);
    tests++; if (bounce_cnt !== 8'd1) begin fails++; $display("FAIL bounce_at_top: got %0d want 1", bounce_cnt); end
    drive(4'd13, 1'b0);
    tests++; if (bounce_cnt !== 8'd1) begin fails++; $display("FAIL bounce_after: got %0d want 1", bounce_cnt); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL bounce_locked: got %b want 1", locked); end
  endtask

  task automatic test_error();
    // Down to zero, reverse (second bounce), up to (15,1).
    for (int v = 12; v >= 0; v--) drive(4'(v), 1'b0);
    for (int v = 1; v <= 15; v++) drive(4'(v), 1'b1);
    tests++; if (bounce_cnt !== 8'd2) begin fails++; $display("FAIL err_pre_bounce: got %0d want 2", bounce_cnt); end
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL err_pre_pulse: got %b want 0", err_pulse); end
    drive(4'd0, 1'b1);  // illegal wrap 15 -> 0
    tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL err_pulse_hi: got %b want 1", err_pulse); end
    tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL err_cnt_1: got %0d want 1", err_cnt); end
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL err_fault: got %b want 1", fault); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL err_unlocked: got %b want 0", locked); end
    tests++; if (bounce_cnt !== 8'd2) begin fails++; $display("FAIL err_bounce_hold: got %0d want 2", bounce_cnt); end
    drive(4'd1, 1'b1);
    tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL err_pulse_once: got %b want 0", err_pulse); end
    drive(4'd7, 1'b0);
    tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL fault_err_hold: got %0d want 1", err_cnt); end
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL fault_sticky: got %b want 1", fault); end
  endtask

  task automatic test_clear();
    clear = 1'b1;
    drive(4'd5, 1'b1);
    clear = 1'b0;
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL clr_fault: got %b want 0", fault); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
    tests++; if (bounce_cnt !== 8'd2) begin fails++; $display("FAIL clr_bounce: got %0d want 2", bounce_cnt); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL clr_locked: got %b want 0", locked); end
    // Had (5,1) been captured, (6,1),(7,1) would complete a lock.
    drive(4'd6, 1'b1);
    drive(4'd7, 1'b1);
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL clr_discard: got %b want 0", locked); end
    drive(4'd8, 1'b1);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL clr_relock: got %b want 1", locked); end
  endtask

  task automatic test_resync();
    logic saw_err;
    saw_err = 1'b0;
    do_clear();
    drive(4'd3, 1'b1);  saw_err |= err_pulse;
    drive(4'd4, 1'b1);  saw_err |= err_pulse;
    drive(4'd9, 1'b1);  saw_err |= err_pulse;
    drive(4'd10, 1'b1); saw_err |= err_pulse;
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL resync_10: got %b want 0", locked); end
    drive(4'd11, 1'b1); saw_err |= err_pulse;
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL resync_11: got %b want 1", locked); end
    tests++; if (saw_err !== 1'b0) begin fails++; $display("FAIL resync_pulse: got %b want 0", saw_err); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL resync_err_cnt: got %0d want 0", err_cnt); end
  endtask

  task automatic test_boundaries();
    // (0,x) -> (15,0) is illegal.
    do_clear();
    drive(4'd2, 1'b0);
    drive(4'd1, 1'b0);
    drive(4'd0, 1'b0);
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL bnd_lock_down: got %b want 1", locked); end
    drive(4'd15, 1'b0);
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL bnd_0_to_15: got %b want 1", fault); end
    tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL bnd_err_cnt: got %0d want 1", err_cnt); end
    // Right value, wrong direction flag is also illegal.
    do_clear();
    drive(4'd5, 1'b1);
    drive(4'd6, 1'b1);
    drive(4'd7, 1'b1);
    drive(4'd8, 1'b0);
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL bnd_dir_flag: got %b want 1", fault); end
    tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL bnd_dir_err_cnt: got %0d want 1", err_cnt); end
  endtask

  task automatic test_async_reset();
    // Currently in FAULT with err_cnt = 1 and bounce_cnt = 2.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL arst_fault: got %b want 0", fault); end
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL arst_err_cnt: got %0d want 0", err_cnt); end
    tests++; if (bounce_cnt !== 8'd0) begin fails++; $display("FAIL arst_bounce: got %0d want 0", bounce_cnt); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL arst_locked: got %b want 0", locked); end
    #2;
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_saturation();
    logic [3:0] v;
    logic       d;
    int         reversals;
    logic       saw_err;
    v = 4'd0; d = 1'b1; reversals = 0; saw_err = 1'b0;
    drive(4'd0, 1'b1);
    drive(4'd1, 1'b1);
    drive(4'd2, 1'b1);
    v = 4'd2;
    while (reversals < 300) begin
      if (v == 4'd15 && d) begin d = 1'b0; reversals++; end
      else if (v == 4'd0 && !d) begin d = 1'b1; reversals++; end
      v = d ? v + 4'd1 : v - 4'd1;
      drive(v, d);
      saw_err |= err_pulse;
      if (reversals == 10 && (v == 4'd14 || v == 4'd1)) begin
        tests++; if (bounce_cnt !== 8'd10) begin fails++; $display("FAIL sat_mid: got %0d want 10", bounce_cnt); end
      end
    end
    tests++; if (bounce_cnt !== 8'd255) begin fails++; $display("FAIL sat_hold: got %0d want 255", bounce_cnt); end
    tests++; if (saw_err !== 1'b0) begin fails++; $display("FAIL sat_no_err: got %b want 0", saw_err); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL sat_locked: got %b want 1", locked); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_bounce();
    test_error();
    test_clear();
    test_resync();
    test_boundaries();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
